// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg -- shared types and constants for the data-memory arbiter.
// Owner-state encoding, the fixed word-size func3 used for debug accesses,
// and a width helper for the starvation counter.
package dmem_arbiter_pkg;

   // Owner of the memory port in the previous cycle
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CORE = 2'd1,
      S_DBG  = 2'd2
   } owner_e;

   // Debug accesses are always full-word
   localparam logic [2:0] DBG_WORD_FUNC3 = 3'b010;

   // Bits needed to hold 0..max inclusive (at least one bit)
   function automatic int cnt_width(input int max);
      return (max < 1) ? 1 : $clog2(max + 1);
   endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// dmem_starve_ctr -- saturating wait counter for the debug port.
// Counts up on i_inc, stops at MAX, clears on i_clr. o_sat flags MAX reached.
module dmem_starve_ctr
   import dmem_arbiter_pkg::*;
#(
   parameter int MAX = 8
)(
   input  logic clk,
   input  logic reset,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_sat
);

   localparam int CW = cnt_width(MAX);
   localparam logic [CW-1:0] MAX_C = CW'(MAX);

   logic [CW-1:0] r_cnt;

   // Saturating count; clear has priority over increment
   always_ff @(posedge clk) begin
      if (reset || i_clr)
         r_cnt <= '0;
      else if (i_inc && (r_cnt != MAX_C))
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_sat = (r_cnt == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- shares one data-memory port between the core MEM stage and a
// debug port. Owner is chosen combinationally each cycle; the core is stalled
// whenever it requests while debug holds the port.
// Default build: fixed core priority, debug forced through after STARVE_MAX
// consecutive wait cycles.
// Build option DMEM_ARB_FAIR_EN: on contention the port alternates, the winner
// being whichever side did not own the previous cycle.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int DM_ADDRESS = 9,
   parameter int STARVE_MAX = 8
)(
   input  logic                  clk,
   input  logic                  reset,
   // core MEM stage
   input  logic                  core_rd,
   input  logic                  core_wr,
   input  logic [DM_ADDRESS-1:0] core_addr,
   input  logic [DATA_W-1:0]     core_wdata,
   input  logic [2:0]            core_func3,
   output logic [DATA_W-1:0]     core_rdata,
   output logic                  core_stall,
   // debug port
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [DM_ADDRESS-1:0] dbg_addr,
   input  logic [DATA_W-1:0]     dbg_wdata,
   output logic                  dbg_gnt,
   output logic                  dbg_rvalid,
   output logic [DATA_W-1:0]     dbg_rdata,
   // memory
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [DM_ADDRESS-1:0] mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [2:0]            mem_func3,
   input  logic [DATA_W-1:0]     mem_rdata
);

   owner_e              r_owner_q;
   owner_e              w_owner_d;
   logic                w_core_req;
   logic                w_dbg_win;
   logic                w_starve_sat;
   logic                w_starve_inc;
   logic                w_starve_clr;
   logic                r_rvalid;
   logic [DATA_W-1:0]   r_rdata;

   // A simultaneous read+write from the core is illegal and resolves as a write
   assign w_core_req = core_rd | core_wr;

`ifdef DMEM_ARB_FAIR_EN
   // Alternating grant needs no wait history
   assign w_starve_inc = 1'b0;
   assign w_starve_clr = 1'b1;
`else
   // Debug accumulates wait cycles only while it asks and is refused
   assign w_starve_inc = dbg_req & ~dbg_gnt;
   assign w_starve_clr = ~dbg_req | dbg_gnt;
`endif

   dmem_starve_ctr #(
      .MAX   (STARVE_MAX)
   ) u_starve (
      .clk   (clk),
      .reset (reset),
      .i_inc (w_starve_inc),
      .i_clr (w_starve_clr),
      .o_sat (w_starve_sat)
   );

   // Owner register: remembers who held the port last cycle
   always_ff @(posedge clk) begin
      if (reset)
         r_owner_q <= S_IDLE;
      else
         r_owner_q <= w_owner_d;
   end

   // Grant decision, next owner and memory-port mux; everything idles in reset
   always_comb begin
      w_dbg_win  = 1'b0;
      w_owner_d  = S_IDLE;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_func3  = '0;
      dbg_gnt    = 1'b0;
      core_stall = 1'b0;
      core_rdata = '0;
      if (!reset) begin
         if (dbg_req && w_core_req) begin
`ifdef DMEM_ARB_FAIR_EN
            w_dbg_win = (r_owner_q == S_CORE);
`else
            w_dbg_win = w_starve_sat;
`endif
         end else begin
            w_dbg_win = dbg_req;
         end

         if (w_dbg_win) begin
            w_owner_d  = S_DBG;
            dbg_gnt    = 1'b1;
            core_stall = w_core_req;
            mem_rd     = ~dbg_we;
            mem_wr     = dbg_we;
            mem_addr   = dbg_addr;
            mem_wdata  = dbg_wdata;
            mem_func3  = DBG_WORD_FUNC3;
         end else if (w_core_req) begin
            w_owner_d  = S_CORE;
            mem_rd     = ~core_wr;
            mem_wr     = core_wr;
            mem_addr   = core_addr;
            mem_wdata  = core_wdata;
            mem_func3  = core_func3;
            core_rdata = mem_rdata;
         end
      end
   end

   // Debug read return: capture at the grant edge, valid for the next cycle only
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= dbg_gnt & ~dbg_we;
         if (dbg_gnt && !dbg_we)
            r_rdata <= mem_rdata;
      end
   end

   // Reset must kill a pending return pulse in the same cycle it is asserted
   assign dbg_rvalid = r_rvalid & ~reset;
   assign dbg_rdata  = reset ? '0 : r_rdata;

   // Never a read and a write in the same cycle
   a_one_access : assert property (@(posedge clk) !(mem_rd && mem_wr));

   // A stalled core keeps its request up into the following cycle
   a_stall_hold : assert property (@(posedge clk) disable iff (reset)
      ((r_owner_q == S_DBG) && $past(core_stall)) |-> w_core_req);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter -- directed vector table, multi-cycle arbitration sequences
// and randomized traffic against a behavioural reference model.
// Honours DMEM_ARB_FAIR_EN when the build defines it.
module tb_dmem_arbiter;

   localparam int DW   = 32;
   localparam int AW   = 9;
   localparam int SMAX = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          core_rd, core_wr;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata;
   logic [2:0]    core_func3;
   logic [DW-1:0] core_rdata;
   logic          core_stall;
   logic          dbg_req, dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic          dbg_gnt, dbg_rvalid;
   logic [DW-1:0] dbg_rdata;
   logic          mem_rd, mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [2:0]    mem_func3;
   logic [DW-1:0] mem_rdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.DATA_W(DW), .DM_ADDRESS(AW), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .reset(reset),
      .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_func3(core_func3),
      .core_rdata(core_rdata), .core_stall(core_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
      .dbg_rdata(dbg_rdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
   );

   typedef struct packed {
      logic          mrd, mwr;
      logic [AW-1:0] maddr;
      logic [DW-1:0] mwd;
      logic [2:0]    mf3;
      logic          stall, gnt;
      logic [DW-1:0] crd;
      logic          rv;
      logic [DW-1:0] drd;
   } out_t;

   typedef struct {
      logic          rst, crd, cwr;
      logic [AW-1:0] caddr;
      logic [DW-1:0] cwd;
      logic [2:0]    cf3;
      logic          dreq, dwe;
      logic [AW-1:0] daddr;
      logic [DW-1:0] dwd;
      logic [DW-1:0] mrd;
      out_t          exp;
   } vec_t;

   // ---------------- reference model ----------------
   int            m_last;        // 0 none, 1 core, 2 debug owned last cycle
   int            m_wait;        // consecutive refused debug cycles
   bit            m_pend;        // debug read return due this cycle
   logic [DW-1:0] m_rdata;
   bit            m_prev_stall;

   function automatic bit model_dwin();
      bit creq;
      creq = core_rd | core_wr;
      if (!dbg_req) return 1'b0;
      if (!creq)    return 1'b1;
`ifdef DMEM_ARB_FAIR_EN
      return (m_last == 1);
`else
      return (m_wait >= SMAX);
`endif
   endfunction

   function automatic out_t model_out();
      out_t e;
      bit   creq, dw;
      e    = '0;
      creq = core_rd | core_wr;
      if (!reset) begin
         dw = model_dwin();
         if (dw) begin
            e.mrd = !dbg_we; e.mwr = dbg_we; e.maddr = dbg_addr;
            e.mwd = dbg_wdata; e.mf3 = 3'b010; e.gnt = 1'b1; e.stall = creq;
         end else if (creq) begin
            e.mrd = !core_wr; e.mwr = core_wr; e.maddr = core_addr;
            e.mwd = core_wdata; e.mf3 = core_func3; e.crd = mem_rdata;
         end
         e.rv  = m_pend;
         e.drd = m_rdata;
      end
      return e;
   endfunction

   task automatic model_step();
      bit creq, dgr;
      creq = core_rd | core_wr;
      if (reset) begin
         m_last = 0; m_wait = 0; m_pend = 0; m_rdata = '0; m_prev_stall = 0;
      end else begin
         dgr          = model_dwin();
         m_prev_stall = dgr && creq;
         m_pend       = dgr && !dbg_we;
         if (m_pend) m_rdata = mem_rdata;
`ifdef DMEM_ARB_FAIR_EN
         m_wait = 0;
`else
         if (dbg_req && !dgr) m_wait = (m_wait < SMAX) ? m_wait + 1 : m_wait;
         else                 m_wait = 0;
`endif
         m_last = dgr ? 2 : (creq ? 1 : 0);
      end
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input out_t e);
      chk({tag, ".mem_rd"},     DW'(mem_rd),     DW'(e.mrd));
      chk({tag, ".mem_wr"},     DW'(mem_wr),     DW'(e.mwr));
      chk({tag, ".mem_addr"},   DW'(mem_addr),   DW'(e.maddr));
      chk({tag, ".mem_wdata"},  mem_wdata,       e.mwd);
      chk({tag, ".mem_func3"},  DW'(mem_func3),  DW'(e.mf3));
      chk({tag, ".core_stall"}, DW'(core_stall), DW'(e.stall));
      chk({tag, ".dbg_gnt"},    DW'(dbg_gnt),    DW'(e.gnt));
      chk({tag, ".core_rdata"}, core_rdata,      e.crd);
      chk({tag, ".dbg_rvalid"}, DW'(dbg_rvalid), DW'(e.rv));
      chk({tag, ".dbg_rdata"},  dbg_rdata,       e.drd);
   endtask

   task automatic drive_idle();
      core_rd = 0; core_wr = 0; core_addr = '0; core_wdata = '0; core_func3 = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; mem_rdata = '0;
   endtask

   // advance one clock: model absorbs this cycle, inputs change 1 after the edge
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(
      logic rst, logic crd, logic cwr, logic [AW-1:0] caddr, logic [DW-1:0] cwd,
      logic [2:0] cf3, logic dreq, logic dwe, logic [AW-1:0] daddr,
      logic [DW-1:0] dwd, logic [DW-1:0] mrd,
      logic e_mrd, logic e_mwr, logic [AW-1:0] e_maddr, logic [DW-1:0] e_mwd,
      logic [2:0] e_mf3, logic e_stall, logic e_gnt, logic [DW-1:0] e_crd,
      logic e_rv, logic [DW-1:0] e_drd);
      vec_t v;
      v.rst = rst; v.crd = crd; v.cwr = cwr; v.caddr = caddr; v.cwd = cwd;
      v.cf3 = cf3; v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
      v.mrd = mrd;
      v.exp.mrd = e_mrd; v.exp.mwr = e_mwr; v.exp.maddr = e_maddr;
      v.exp.mwd = e_mwd; v.exp.mf3 = e_mf3; v.exp.stall = e_stall;
      v.exp.gnt = e_gnt; v.exp.crd = e_crd; v.exp.rv = e_rv; v.exp.drd = e_drd;
      return v;
   endfunction

   // contention with core held; debug must break through on schedule
   task automatic seq_priority();
      bit g, rv;
      for (int i = 0; i < 20; i++) begin
         core_rd = 1; core_wr = 0; core_addr = 9'h040; core_func3 = 3'b010;
         dbg_req = 1; dbg_we = 0; dbg_addr = 9'h044; mem_rdata = 32'h1000 + i;
         @(negedge clk);
`ifdef DMEM_ARB_FAIR_EN
         g  = (i % 2 == 1);
         rv = (i >= 2) && (i % 2 == 0);
`else
         g  = (i == 8) || (i == 17);
         rv = (i == 9) || (i == 18);
`endif
         chk("prio.dbg_gnt",    DW'(dbg_gnt),    DW'(g));
         chk("prio.core_stall", DW'(core_stall), DW'(g));
         chk("prio.mem_addr",   DW'(mem_addr),   g ? 32'h044 : 32'h040);
         chk("prio.dbg_rvalid", DW'(dbg_rvalid), DW'(rv));
         if (rv) chk("prio.dbg_rdata", dbg_rdata, 32'h1000 + i - 1);
         tick();
      end
      dbg_req = 0;          // let the core finish its held request
      @(negedge clk); tick();
      drive_idle();
      @(negedge clk); tick();
   endtask

   // wait history must restart after dbg_req drops or after reset
   task automatic seq_starve_break(input bit use_reset);
      for (int i = 0; i < 16; i++) begin
         core_rd = 1; core_wr = 0; core_addr = 9'h080; core_func3 = 3'b010;
         dbg_req = 1; dbg_we = 1; dbg_addr = 9'h084; dbg_wdata = 32'hA5A5_0000 + i;
         reset = 0;
         if (i == 5) begin
            if (use_reset) reset = 1;
            else           dbg_req = 0;
         end
         @(negedge clk);
         chk(use_reset ? "rst_brk.dbg_gnt" : "drop_brk.dbg_gnt", DW'(dbg_gnt), DW'(i == 14));
         chk(use_reset ? "rst_brk.core_stall" : "drop_brk.core_stall", DW'(core_stall), DW'(i == 14));
         tick();
      end
      drive_idle(); reset = 0;
      @(negedge clk); tick();
   endtask

   vec_t tbl[17];
   out_t e;
   logic cur_rd, cur_wr;

   initial begin
      m_last = 0; m_wait = 0; m_pend = 0; m_rdata = '0; m_prev_stall = 0;
      drive_idle();
      reset = 1;
      @(posedge clk); #1;

      //          rst crd cwr caddr   cwd           cf3  dreq dwe daddr   dwd           mrd          | mrd mwr maddr  mwd          mf3  stl gnt crd           rv drd
      tbl[0]  = mk(1, 0, 1, 9'h010, 32'hDEADBEEF, 3'd2, 1, 0, 9'h010, 32'h0,        32'h0,          0, 0, 9'h000, 32'h0,        3'd0, 0, 0, 32'h0,        0, 32'h0);
      tbl[1]  = mk(0, 0, 0, 9'h000, 32'h0,        3'd0, 0, 0, 9'h000, 32'h0,        32'h0,          0, 0, 9'h000, 32'h0,        3'd0, 0, 0, 32'h0,        0, 32'h0);
      tbl[2]  = mk(0, 0, 1, 9'h010, 32'hDEADBEEF, 3'd2, 0, 0, 9'h000, 32'h0,        32'h0,          0, 1, 9'h010, 32'hDEADBEEF, 3'd2, 0, 0, 32'h0,        0, 32'h0);
      tbl[3]  = mk(0, 1, 0, 9'h010, 32'h0,        3'd4, 0, 0, 9'h000, 32'h0,        32'hDEADBEEF,   1, 0, 9'h010, 32'h0,        3'd4, 0, 0, 32'hDEADBEEF, 0, 32'h0);
      tbl[4]  = mk(0, 0, 0, 9'h000, 32'h0,        3'd0, 1, 0, 9'h010, 32'h0,        32'hDEADBEEF,   1, 0, 9'h010, 32'h0,        3'd2, 0, 1, 32'h0,        0, 32'h0);
      tbl[5]  = mk(0, 0, 0, 9'h000, 32'h0,        3'd0, 0, 0, 9'h000, 32'h0,        32'h11111111,   0, 0, 9'h000, 32'h0,        3'd0, 0, 0, 32'h0,        1, 32'hDEADBEEF);
      tbl[6]  = mk(0, 0, 0, 9'h000, 32'h0,        3'd0, 1, 0, 9'h004, 32'h0,        32'hA0A0A0A0,   1, 0, 9'h004, 32'h0,        3'd2, 0, 1, 32'h0,        0, 32'hDEADBEEF);
      tbl[7]  = mk(0, 0, 0, 9'h000, 32'h0,        3'd0, 1, 0, 9'h008, 32'h0,        32'hB0B0B0B0,   1, 0, 9'h008, 32'h0,        3'd2, 0, 1, 32'h0,        1, 32'hA0A0A0A0);
      tbl[8]  = mk(0, 0, 0, 9'h000, 32'h0,        3'd0, 0, 0, 9'h000, 32'h0,        32'h0,          0, 0, 9'h000, 32'h0,        3'd0, 0, 0, 32'h0,        1, 32'hB0B0B0B0);
      tbl[9]  = mk(0, 0, 0, 9'h000, 32'h0,        3'd0, 1, 1, 9'h00C, 32'h12345678, 32'h99,         0, 1, 9'h00C, 32'h12345678, 3'd2, 0, 1, 32'h0,        0, 32'hB0B0B0B0);
      tbl[10] = mk(0, 0, 0, 9'h000, 32'h0,        3'd0, 0, 0, 9'h000, 32'h0,        32'h0,          0, 0, 9'h000, 32'h0,        3'd0, 0, 0, 32'h0,        0, 32'hB0B0B0B0);
      tbl[11] = mk(0, 1, 1, 9'h020, 32'h55,       3'd0, 0, 0, 9'h000, 32'h0,        32'h77,         0, 1, 9'h020, 32'h55,       3'd0, 0, 0, 32'h77,       0, 32'hB0B0B0B0);
      tbl[12] = mk(0, 0, 0, 9'h000, 32'h0,        3'd0, 1, 0, 9'h030, 32'h0,        32'hCAFEF00D,   1, 0, 9'h030, 32'h0,        3'd2, 0, 1, 32'h0,        0, 32'hB0B0B0B0);
      tbl[13] = mk(1, 1, 0, 9'h040, 32'h0,        3'd2, 1, 0, 9'h044, 32'h0,        32'h3,          0, 0, 9'h000, 32'h0,        3'd0, 0, 0, 32'h0,        0, 32'h0);
      tbl[14] = mk(0, 0, 0, 9'h000, 32'h0,        3'd0, 0, 0, 9'h000, 32'h0,        32'h0,          0, 0, 9'h000, 32'h0,        3'd0, 0, 0, 32'h0,        0, 32'h0);
      tbl[15] = mk(0, 1, 0, 9'h050, 32'h0,        3'd2, 1, 0, 9'h060, 32'h0,        32'h5A,         1, 0, 9'h050, 32'h0,        3'd2, 0, 0, 32'h5A,       0, 32'h0);
      tbl[16] = mk(0, 0, 0, 9'h000, 32'h0,        3'd0, 0, 0, 9'h000, 32'h0,        32'h0,          0, 0, 9'h000, 32'h0,        3'd0, 0, 0, 32'h0,        0, 32'h0);

      for (int k = 0; k < 17; k++) begin
         reset = tbl[k].rst; core_rd = tbl[k].crd; core_wr = tbl[k].cwr;
         core_addr = tbl[k].caddr; core_wdata = tbl[k].cwd; core_func3 = tbl[k].cf3;
         dbg_req = tbl[k].dreq; dbg_we = tbl[k].dwe; dbg_addr = tbl[k].daddr;
         dbg_wdata = tbl[k].dwd; mem_rdata = tbl[k].mrd;
         @(negedge clk);
         chk_all($sformatf("tbl%0d", k), tbl[k].exp);
         tick();
      end
      reset = 0;

      seq_priority();
`ifndef DMEM_ARB_FAIR_EN
      seq_starve_break(1'b0);
      seq_starve_break(1'b1);
`endif

      // randomized traffic; a stalled core keeps its request unchanged
      cur_rd = 0; cur_wr = 0;
      for (int n = 0; n < 600; n++) begin
         int r;
         reset = ($urandom_range(0, 39) == 0);
         if (!m_prev_stall) begin
            r = $urandom_range(0, 9);
            core_rd    = (r < 4) || (r == 9);
            core_wr    = (r >= 4 && r < 8) || (r == 9);
            core_addr  = AW'($urandom);
            core_wdata = $urandom;
            core_func3 = 3'($urandom);
         end
         if ($urandom_range(0, 5) == 0) dbg_req = ~dbg_req;
         dbg_we    = $urandom_range(0, 1);
         dbg_addr  = AW'($urandom);
         dbg_wdata = $urandom;
         mem_rdata = $urandom;
         @(negedge clk);
         e = model_out();
         chk_all("rand", e);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data width of memory and both ports.
REQ-002 Parameter DM_ADDRESS, default 9, data-memory byte address width.
REQ-003 Parameter STARVE_MAX, default 8, consecutive debug-wait cycles before debug is forced ahead of core.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 core_rd, core_wr  input  1 each  MEM-stage read/write request.
REQ-007 core_addr  input  DM_ADDRESS  core byte address; core_wdata input DATA_W; core_func3 input 3  access size/sign.
REQ-008 core_rdata  output  DATA_W  read data to MEM/WB; core_stall  output 1  hold EX/MEM, IF/ID, PC.
REQ-009 dbg_req, dbg_we  input  1 each  debug access request and write select.
REQ-010 dbg_addr  input  DM_ADDRESS  debug address; dbg_wdata  input  DATA_W  debug write data.
REQ-011 dbg_gnt  output 1  accept pulse; dbg_rvalid  output 1  read-data valid; dbg_rdata  output DATA_W.
REQ-012 mem_rd, mem_wr  output 1 each; mem_addr  output DM_ADDRESS; mem_wdata  output DATA_W; mem_func3  output 3.
REQ-013 mem_rdata  input  DATA_W  combinational read data of the granted access, same cycle.

Function
REQ-014 Owner decided combinationally each cycle; FSM state owner_q in {S_IDLE, S_CORE, S_DBG} records last cycle's owner.
REQ-015 Core request = core_rd|core_wr; core_rd&core_wr together is illegal and treated as write.
REQ-016 Only core requesting: core granted, mem_* driven from core_*, core_stall=0.
REQ-017 Only debug requesting: debug granted, dbg_gnt=1, mem_rd=~dbg_we, mem_wr=dbg_we, mem_func3=3'b010 (word).
REQ-018 Both requesting: core wins unless starve_cnt==STARVE_MAX, then debug wins and core_stall=1 for that cycle.
REQ-019 core_stall=1 exactly when core requests and debug is granted; core must hold request stable while stalled.
REQ-020 starve_cnt increments while dbg_req=1 and not granted, saturates at STARVE_MAX, clears on debug grant or dbg_req=0.
REQ-021 Debug read: mem_rdata captured into dbg_rdata at grant edge; dbg_rvalid=1 for exactly the following cycle.
REQ-022 Debug write: no dbg_rvalid; dbg_rdata holds its previous value.
REQ-023 Back-to-back debug grants allowed; dbg_rvalid of access N may coincide with dbg_gnt of access N+1.
REQ-024 core_rdata=mem_rdata whenever core owns the cycle, else 0.
REQ-025 Neither requesting: mem_rd=mem_wr=0, mem_addr/mem_wdata/mem_func3=0, owner_q<=S_IDLE.
REQ-026 No memory access occurs without a grant; at most one access per cycle.

Reset
REQ-027 While reset=1: owner_q=S_IDLE, starve_cnt=0, dbg_rvalid=0, dbg_rdata=0, dbg_gnt=0, core_stall=0, all mem_* = 0.
REQ-028 Reset during a pending debug read cancels the dbg_rvalid pulse; requests present in the reset cycle are ignored.

Configuration
REQ-029 Macro DMEM_ARB_FAIR_EN defined: when both request, grant alternates — winner is the port not granted last (from owner_q), starve_cnt unused and held 0.
REQ-030 DMEM_ARB_FAIR_EN undefined: fixed core priority with starvation override per REQ-018/REQ-020.

Structure
REQ-031 Shared package holds owner state enum (S_IDLE, S_CORE, S_DBG) and DBG_WORD_FUNC3=3'b010 constant.
REQ-032 One sub-module dmem_starve_ctr (saturating counter, inc/clr, sat flag); grant logic and FSM stay in dmem_arbiter.

Verification
REQ-033 Core-only: core_wr=1, addr=0x010, wdata=0xDEADBEEF -> mem_wr=1 same cycle, core_stall=0, dbg_gnt=0.
REQ-034 Debug-only read at 0x010 with mem_rdata=0xDEADBEEF -> dbg_gnt=1 cycle 0, dbg_rvalid=1 and dbg_rdata=0xDEADBEEF cycle 1.
REQ-035 Core continuous + dbg_req held (fixed priority) -> core granted 8 cycles, debug granted cycle 9 with core_stall=1 that cycle only.
REQ-036 FAIR_EN, both requesting 6 cycles from S_IDLE -> grants core,dbg,core,dbg,core,dbg; core_stall on dbg cycles.
REQ-037 Reset asserted in cycle after debug read grant -> dbg_rvalid stays 0, starve_cnt=0, all outputs 0.
REQ-038 Two back-to-back debug reads (0x004, 0x008) -> dbg_gnt both cycles, dbg_rvalid cycles 1 and 2 with respective data.
